fnd_scan_controller: RTL
========================

Name: fnd_scan_controller

Overview:
Parametrised N-digit multiplexed 7-segment (FND) driver. It is the successor to the fixed 4-digit/1 kHz controller.
- Binary-to-BCD conversion is a sequential double-dabble unit with an atomic display commit, replacing the combinational divide/modulo.
- Adds per-digit decimal points, leading-zero blanking, per-digit blink and overflow indication.
- Sits between register/peripheral logic (SPI slave, counters) and the board FND pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
DATA_W, 14, width of binary input value
SCAN_DIV, 100_000, clk cycles per digit slot (1 kHz slot rate at 100 MHz)
BLINK_DIV, 250, scan ticks per blink half-period (250 ticks at 1 kHz slot rate = 2 Hz blink)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (sampled on rising clk)
fndData  in  DATA_W  unsigned binary value to display
data_valid  in  1  load request; accepted when busy=0
fndDot  in  NUM_DIGITS  per-digit decimal point, active-high, bit0 = rightmost digit
blank_lz  in  1  1 = blank leading zeros
blink_mask  in  NUM_DIGITS  1 = digit blinks
busy  out  1  conversion in progress
overflow  out  1  committed value exceeds 10^NUM_DIGITS-1
fndCom  out  NUM_DIGITS  digit enables, active-low, one-cold
fndFont  out  8  segments {dp,g..a}, active-low

Behaviour:
- Reset (reset=0 at clk edge):
  - Output values: fndCom all 1, fndFont 8'hFF, busy 0, overflow 0.
  - Internal state: display BCD register 0, scan index 0, divider 0, blink phase 0, FSM IDLE.
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE + data_valid: latch fndData; compare it against MAX_VAL = 10^NUM_DIGITS-1 and latch ovf_pending; clear BCD accumulator; shift counter = DATA_W; busy=1; go to SHIFT.
  - SHIFT, one bit per cycle: add 3 to every BCD nibble >=5, then shift {bcd, bin} left by 1. After DATA_W cycles go to COMMIT.
  - COMMIT: copy the accumulator to the display register and ovf_pending to overflow in a single cycle; busy=0; go to IDLE.
  - Latency: data_valid accepted at edge T → display register updated at edge T+DATA_W+1; busy high for DATA_W+1 cycles.
  - data_valid while busy=1 is ignored, not queued. The source must hold or re-issue it.
  - The BCD accumulator is NUM_DIGITS nibbles wide. On overflow its contents are don't-care and the display shows dashes.
- Scan:
  - The divider counts 0..SCAN_DIV-1 and pulses scan_tick on the wrap.
  - On scan_tick the scan index advances 0..NUM_DIGITS-1 and wraps to 0.
  - The blink counter counts scan_ticks; it toggles blink_phase every BLINK_DIV ticks.
- Output stage (registered, one cycle after the index/display change):
  - fndCom[i] = 0 only for i = scan index.
  - fndFont[6:0]:
    - If overflow=1: dash 7'h3F.
    - Else if the digit is blanked: 7'h7F.
    - Else: seg(digit).
  - Blanking:
    - A digit is blanked if blink_mask[idx]=1 and blink_phase=1.
    - A digit is also blanked if blank_lz=1, idx>0, and all nibbles at positions >= idx are 0. Digit 0 is never LZ-blanked.
  - fndFont[7] = ~fndDot[idx]. The dp is also forced to 1 when the digit is blink-blanked.
- Display register changes only at COMMIT. No partially converted digits are ever shown.
- Reset mid-conversion aborts the conversion. The display returns to 0 and the FSM to IDLE.
- fndDot, blank_lz and blink_mask are sampled live and are not latched by data_valid.

Decomposition:
- Package fnd_pkg holds:
  - Segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
  - Function seg7(nibble) giving active-low {g..a} for 0-F.
  - Function pow10(n) for MAX_VAL.
  - Converter state enum typedef conv_state_t.
- Sub-module bin2bcd_seq (parameters DATA_W, NUM_DIGITS): contains the FSM, accumulator, busy and the COMMIT strobe.
- Scan, blink and output logic live in the top module.

Test Plan:
(NUM_DIGITS=4, DATA_W=14, SCAN_DIV=4, BLINK_DIV=2 for sim)
1. Reset held low 3 cycles, then released → fndCom=4'b1111, fndFont=8'hFF during reset. After the first scan_tick, digit0 shows seg 7'h40 ('0'); busy=0, overflow=0.
2. fndData=1234, data_valid for 1 cycle, blank_lz=0 → busy high 15 cycles. The scan then shows digits 4,3,2,1 with codes 7'h19,7'h30,7'h24,7'h79 on fndCom 1110,1101,1011,0111.
3. fndData=7, blank_lz=1, fndDot=4'b0100 → digit0=7'h78. Digits 1-3 have segments 7'h7F. Digit2 has fndFont=8'h7F (dp lit), digits 1 and 3 have 8'hFF.
4. fndData=12000 → overflow=1 after COMMIT. All digits show 8'hBF. A following load of 9999 clears overflow and shows 9,9,9,9 (7'h10).
5. 5678 loaded, then data_valid with 1111 on the 5th busy cycle → 1111 ignored, display = 5678. blink_mask=4'b0001 → digit0 alternates 7'h78 / 7'h7F every 2 scan ticks; other digits are steady.
6. Load 4321, then assert reset 5 cycles after data_valid → busy=0 and the display shows 0000. The next load of 42 completes normally.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package fnd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter; the display register and overflow flag
// change together only on COMMIT so no half-converted value is ever visible.
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       din,
  input  logic                    load,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    overflow
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  conv_state_t       state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     acc;
  logic [BW-1:0]     adj;
  logic [DATA_W-1:0] sh;
  logic              ovf_pending;

  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign adj = dabble(acc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      cnt         <= '0;
      bcd         <= '0;
      overflow    <= 1'b0;
      ovf_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          state       <= SHIFT;
          busy        <= 1'b1;
          cnt         <= CW'(DATA_W);
          ovf_pending <= 64'(din) > MAX_VAL;
        end
        SHIFT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= COMMIT;
        end
        COMMIT: begin
          bcd      <= acc;
          overflow <= ovf_pending;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift datapath carries no reset; the FSM decides when it is meaningful.
  always_ff @(posedge clk) begin
    if (state == IDLE && load) begin
      acc <= '0;
      sh  <= din;
    end else if (state == SHIFT) begin
      acc <= {adj[BW-2:0], sh[DATA_W-1]};
      sh  <= sh << 1;
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// N-digit multiplexed FND driver: slot divider, digit scan, blink timing,
// blanking and the registered common/segment outputs.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int SCAN_DIV   = 100_000,
  parameter int BLINK_DIV  = 250
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     fndData,
  input  logic                  data_valid,
  input  logic [NUM_DIGITS-1:0] fndDot,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] fndCom,
  output logic [7:0]            fndFont
);

  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BKW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [4*NUM_DIGITS-1:0] disp;
  logic [DVW-1:0]          div;
  logic                    scan_tick;
  logic [IW-1:0]           idx;
  logic [BKW-1:0]          bcnt;
  logic                    blink_phase;
  logic [3:0]              cur_nib;
  logic                    blink_blank;
  logic                    lz_zero;
  logic                    lz_blank;
  logic [6:0]              seg_n;
  logic                    dp_n;

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_conv (
    .clk     (clk),
    .reset   (reset),
    .din     (fndData),
    .load    (data_valid),
    .busy    (busy),
    .bcd     (disp),
    .overflow(overflow)
  );

  assign scan_tick = (div == DVW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      div         <= '0;
      idx         <= '0;
      bcnt        <= '0;
      blink_phase <= 1'b0;
    end else begin
      div <= scan_tick ? '0 : div + DVW'(1);
      if (scan_tick) begin
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        if (bcnt == BKW'(BLINK_DIV - 1)) begin
          bcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          bcnt <= bcnt + BKW'(1);
        end
      end
    end
  end

  // Digit 0 is never leading-zero blanked so a zero value still shows "0".
  always_comb begin
    cur_nib     = disp[4*idx +: 4];
    blink_blank = blink_mask[idx] & blink_phase;
    lz_zero     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (i >= int'(idx) && disp[4*i +: 4] != 4'd0) lz_zero = 1'b0;
    lz_blank = blank_lz && (idx != '0) && lz_zero;
    if (overflow)                     seg_n = SEG_DASH;
    else if (blink_blank || lz_blank) seg_n = SEG_BLANK;
    else                              seg_n = seg7(cur_nib);
    dp_n = ~fndDot[idx] | blink_blank;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fndCom  <= '1;
      fndFont <= 8'hFF;
    end else begin
      fndCom  <= ~(NUM_DIGITS'(1) << idx);
      fndFont <= {dp_n, seg_n};
    end
  end

endmodule
